// File: rtl/io_sched_pkg.sv
// Shared definitions for the I/O port scheduler: FSM encodings and a
// lowest-set-bit helper used to resolve the one-hot strobes.
package io_sched_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } sched_state_e;

  // Index of the lowest set bit; 0 when no bit is set (callers gate on |v).
  function automatic int unsigned lsb_idx(input logic [31:0] v);
    lsb_idx = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        lsb_idx = i;
      end
    end
  endfunction

endpackage

// File: rtl/io_sfifo.sv
// Small synchronous FIFO with first-word-fall-through head, occupancy count
// and asynchronous active-high reset that discards all buffered words.
module io_sfifo #(
  parameter int W  = 19,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rptr_q];
  assign count_o   = cnt_q;

  always_comb begin
    wptr_d = do_push_s ? wptr_q + AW'(1) : wptr_q;
    rptr_d = do_pop_s  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push_s) begin
        mem_q[wptr_q] <= din_i;
      end
    end
  end

endmodule

// File: rtl/io_port_sched.sv
// Port scheduler around the soft processor: buffers input streams, serves
// decoded reads, captures decoded writes and sequences processor reset.
module io_port_sched
  import io_sched_pkg::*;
#(
  parameter int NUIOIN   = 4,
  parameter int NUIOOU   = 4,
  parameter int NBIN     = 19,
  parameter int NBOUT    = 28,
  parameter int FDEPTH   = 2,
  parameter bit HALT_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN*NBIN-1:0]   s_data,
  input  logic [NUIOIN-1:0]        s_valid,
  output logic [NUIOIN-1:0]        s_ready,
  input  logic [NUIOIN-1:0]        req_in,
  output logic [NBIN-1:0]          io_in,
  input  logic [NUIOOU-1:0]        out_en,
  input  logic [NBOUT-1:0]         io_out,
  output logic [NUIOOU*NBOUT-1:0]  m_data,
  output logic [NUIOOU-1:0]        m_valid,
  input  logic [NUIOOU-1:0]        m_ready,
  input  logic                     clr_err,
  output logic                     proc_rst,
  output logic [NUIOIN-1:0]        err_uf,
  output logic [NUIOOU-1:0]        err_ov,
  output logic [1:0]               state
);

  localparam int IW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int OW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  sched_state_e               state_q, state_d;
  logic                       proc_rst_q;
  logic                       rdy_en_q;
  logic [NUIOOU-1:0]          m_valid_q, m_valid_d;
  logic [NUIOOU*NBOUT-1:0]    m_data_q, m_data_d;
  logic [NUIOIN-1:0]          err_uf_q, err_uf_d;
  logic [NUIOOU-1:0]          err_ov_q, err_ov_d;

  logic [NBIN-1:0]            head_s [NUIOIN];
  logic [FDEPTH:0]            cnt_s  [NUIOIN];
  logic [NUIOIN-1:0]          full_s, empty_s, push_s, pop_s, uf_set_s;
  logic [NUIOOU-1:0]          ov_set_s;
  logic [IW-1:0]              in_sel_s;
  logic [OW-1:0]              out_sel_s;
  logic                       rd_any_s, wr_any_s, primed_s;

  // Strobes only act while the processor is out of reset.
  assign rd_any_s  = (|req_in) & ~proc_rst_q;
  assign wr_any_s  = (|out_en) & ~proc_rst_q;
  assign in_sel_s  = IW'(lsb_idx(32'(req_in)));
  assign out_sel_s = OW'(lsb_idx(32'(out_en)));

  assign s_ready = {NUIOIN{rdy_en_q}} & ~full_s;
  assign io_in   = (rd_any_s && !empty_s[in_sel_s]) ? head_s[in_sel_s] : '0;

  for (genvar i = 0; i < NUIOIN; i++) begin : g_fifo
    assign push_s[i] = s_valid[i] & s_ready[i];
    assign pop_s[i]  = rd_any_s & (in_sel_s == IW'(i)) & ~empty_s[i];
    io_sfifo #(.W(NBIN), .AW(FDEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push_s[i]),
      .pop_i   (pop_s[i]),
      .din_i   (s_data[i*NBIN +: NBIN]),
      .dout_o  (head_s[i]),
      .count_o (cnt_s[i]),
      .full_o  (full_s[i]),
      .empty_o (empty_s[i])
    );
  end

  always_comb begin
    primed_s = 1'b1;
    for (int i = 0; i < NUIOIN; i++) begin
      if (cnt_s[i] == '0) begin
        primed_s = 1'b0;
      end else begin
        primed_s = primed_s;
      end
    end
  end

  always_comb begin
    uf_set_s = '0;
    if (rd_any_s && empty_s[in_sel_s]) begin
      uf_set_s[in_sel_s] = 1'b1;
    end else begin
      uf_set_s = '0;
    end
  end

  // A capture into a still-unaccepted register is an overflow; ready clears first.
  always_comb begin
    m_valid_d = m_valid_q & ~m_ready;
    m_data_d  = m_data_q;
    ov_set_s  = '0;
    if (wr_any_s) begin
      m_valid_d[out_sel_s]                = 1'b1;
      m_data_d[out_sel_s*NBOUT +: NBOUT] = io_out;
      ov_set_s[out_sel_s]                 = m_valid_q[out_sel_s] & ~m_ready[out_sel_s];
    end else begin
      ov_set_s = '0;
    end
  end

  always_comb begin
    if (clr_err) begin
      err_uf_d = '0;
      err_ov_d = '0;
    end else begin
      err_uf_d = err_uf_q | uf_set_s;
      err_ov_d = err_ov_q | ov_set_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (primed_s) state_d = ST_RUN;
        else          state_d = ST_FILL;
      end
      ST_RUN: begin
        if (HALT_ERR && ((|err_uf_q) || (|err_ov_q)) && !clr_err) state_d = ST_HALT;
        else                                                      state_d = ST_RUN;
      end
      ST_HALT: begin
        if (clr_err) state_d = ST_FILL;
        else         state_d = ST_HALT;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      proc_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      proc_rst_q <= (state_d != ST_RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      m_valid_q <= '0;
      m_data_q  <= '0;
      err_uf_q  <= '0;
      err_ov_q  <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_uf_q  <= err_uf_d;
      err_ov_q  <= err_ov_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign err_uf   = err_uf_q;
  assign err_ov   = err_ov_q;
  assign proc_rst = proc_rst_q;
  assign state    = state_q;

endmodule

// File: tb/tb_io_port_sched.sv
// Self-checking bench for io_port_sched: per-port scoreboard queues for the
// read path, a vector table for the output side, and scripted corner cases.
module tb_io_port_sched;

  localparam int NI    = 4;
  localparam int NO    = 4;
  localparam int NBIN  = 19;
  localparam int NBOUT = 28;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NI*NBIN-1:0]    s_data;
  logic [NI-1:0]         s_valid, s_ready, req_in, err_uf;
  logic [NBIN-1:0]       io_in;
  logic [NO-1:0]         out_en, m_valid, m_ready, err_ov;
  logic [NBOUT-1:0]      io_out;
  logic [NO*NBOUT-1:0]   m_data;
  logic                  clr_err, proc_rst;
  logic [1:0]            state;

  io_port_sched dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .req_in(req_in), .io_in(io_in), .out_en(out_en), .io_out(io_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_err(clr_err),
    .proc_rst(proc_rst), .err_uf(err_uf), .err_ov(err_ov), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0]    oe;
    logic [NBOUT-1:0] dout;
    logic [NO-1:0]    rdy;
    logic [NO-1:0]    exp_v;
    int               idx;
    logic [NBOUT-1:0] exp_d;
  } ovec_t;

  ovec_t           tbl [6];
  logic [NBIN-1:0] sbq [NI][$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [NBOUT-1:0] neg5  = -28'sd5;
  logic [NBOUT-1:0] neg77 = -28'sd77;
  logic [NBIN-1:0]  neg3  = -19'sd3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NBOUT-1:0] mslot(input int j);
    return m_data[j*NBOUT +: NBOUT];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push1(input int p, input logic [NBIN-1:0] val);
    logic exp_rdy;
    s_data[p*NBIN +: NBIN] = val;
    s_valid = 4'(1 << p);
    exp_rdy = (sbq[p].size() < 4);
    #1 chk("s_ready_push", 64'(s_ready[p]), 64'(exp_rdy));
    if (exp_rdy) sbq[p].push_back(val);
    tick();
    s_valid = '0;
  endtask

  task automatic rd(input logic [NI-1:0] req, input bit live);
    int              sel;
    bit              pop;
    logic [NBIN-1:0] exp;
    sel = 0;
    for (int i = NI-1; i >= 0; i--) if (req[i]) sel = i;
    pop = live && (req != '0) && (sbq[sel].size() > 0);
    exp = pop ? sbq[sel][0] : '0;
    req_in = req;
    #1 chk("io_in", 64'(io_in), 64'(exp));
    tick();
    if (pop) void'(sbq[sel].pop_front());
    req_in = '0;
  endtask

  task automatic chk_state(input logic [1:0] st, input logic pr);
    chk("state", 64'(state), 64'(st));
    chk("proc_rst", 64'(proc_rst), 64'(pr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0100, 28'd123456, 4'b0000, 4'b0100, 2, 28'd123456};
    tbl[1] = '{4'b0000, 28'd0,      4'b0100, 4'b0000, 2, 28'd123456};
    tbl[2] = '{4'b1000, neg77,      4'b0000, 4'b1000, 3, neg77};
    tbl[3] = '{4'b1000, 28'd99,     4'b1000, 4'b1000, 3, 28'd99};
    tbl[4] = '{4'b1100, 28'd42,     4'b1000, 4'b0100, 2, 28'd42};
    tbl[5] = '{4'b0000, 28'd0,      4'b1111, 4'b0000, 2, 28'd42};

    rst = 1'b1; s_data = '0; s_valid = '0; req_in = '0; out_en = '0;
    io_out = '0; m_ready = '0; clr_err = 1'b0;
    #2;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk_state(2'b00, 1'b1);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data[63:0]), 64'(0));
    chk("rst_err", 64'({err_uf, err_ov}), 64'(0));
    chk("rst_io_in", 64'(io_in), 64'(0));
    @(negedge clk); rst = 1'b0;
    tick();
    chk("s_ready_after_rst", 64'(s_ready), 64'(4'hF));

    // Priming: no RUN until the last port holds a word.
    push1(0, 19'd5); push1(1, 19'd7); push1(2, 19'd9);
    chk_state(2'b00, 1'b1);
    push1(3, neg3);
    tick();
    chk_state(2'b01, 1'b0);

    // Only the lowest strobe bit is served.
    rd(4'b0110, 1'b1);
    chk("err_uf_multi", 64'(err_uf), 64'(0));
    rd(4'b0100, 1'b1);
    push1(2, 19'd9);

    // Output-side vector table.
    for (int k = 0; k < 6; k++) begin
      out_en = tbl[k].oe; io_out = tbl[k].dout; m_ready = tbl[k].rdy;
      tick();
      out_en = '0; m_ready = '0;
      chk($sformatf("tbl%0d_m_valid", k), 64'(m_valid), 64'(tbl[k].exp_v));
      chk($sformatf("tbl%0d_m_data", k), 64'(mslot(tbl[k].idx)), 64'(tbl[k].exp_d));
      chk($sformatf("tbl%0d_err_ov", k), 64'(err_ov), 64'(0));
    end

    // FIFO full on port 0: held word waits for a pop.
    push1(0, 19'd100); push1(0, 19'd101); push1(0, 19'd102);
    s_data[0 +: NBIN] = 19'd103; s_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1 chk("s_ready_full", 64'(s_ready[0]), 64'(0));
      tick();
    end
    rd(4'b0001, 1'b1);
    s_valid = 4'b0001;
    #1 chk("s_ready_after_pop", 64'(s_ready[0]), 64'(1));
    sbq[0].push_back(19'd103);
    tick();
    s_valid = '0;
    #1 chk("s_ready_refull", 64'(s_ready[0]), 64'(0));
    for (int k = 0; k < 4; k++) rd(4'b0001, 1'b1);
    push1(0, 19'd55);

    // Read order then underflow halts the processor.
    push1(1, 19'd11); push1(1, 19'd22);
    rd(4'b0010, 1'b1); rd(4'b0010, 1'b1); rd(4'b0010, 1'b1);
    chk("err_uf", 64'(err_uf), 64'(4'b0010));
    chk_state(2'b01, 1'b0);
    tick();
    chk_state(2'b10, 1'b1);

    // Strobes are inert in HALT.
    out_en = 4'b0010; io_out = 28'd777;
    rd(4'b0001, 1'b0);
    out_en = '0;
    chk("halt_m_valid", 64'(m_valid), 64'(0));
    chk("halt_m_data1", 64'(mslot(1)), 64'(0));
    chk("halt_err", 64'({err_uf, err_ov}), 64'({4'b0010, 4'b0000}));

    push1(1, 19'd33);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err_uf", 64'({err_uf, err_ov}), 64'(0));
    chk_state(2'b00, 1'b1);
    tick();
    chk_state(2'b01, 1'b0);

    // Overflow on output 0.
    out_en = 4'b0001; io_out = 28'd10; tick(); out_en = '0;
    chk("ov_pre_valid", 64'(m_valid), 64'(4'b0001));
    chk("ov_pre_err", 64'(err_ov), 64'(0));
    out_en = 4'b0001; io_out = neg5; tick(); out_en = '0;
    chk("ov_m_data", 64'(mslot(0)), 64'(neg5));
    chk("ov_err", 64'(err_ov), 64'(4'b0001));
    chk_state(2'b01, 1'b0);
    tick();
    chk_state(2'b10, 1'b1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err_ov", 64'({err_uf, err_ov}), 64'(0));
    chk_state(2'b00, 1'b1);
    chk("keep_m_valid", 64'(m_valid), 64'(4'b0001));
    chk("keep_m_data", 64'(mslot(0)), 64'(neg5));
    tick();
    chk_state(2'b01, 1'b0);

    // Async reset between edges flushes everything at once.
    #2 rst = 1'b1; req_in = 4'b0001;
    #1;
    chk_state(2'b00, 1'b1);
    chk("arst_m_valid", 64'(m_valid), 64'(0));
    chk("arst_s_ready", 64'(s_ready), 64'(0));
    chk("arst_io_in", 64'(io_in), 64'(0));
    req_in = '0;
    for (int i = 0; i < NI; i++) sbq[i].delete();
    @(negedge clk); rst = 1'b0;
    tick();
    chk("arst_s_ready_rel", 64'(s_ready), 64'(4'hF));
    push1(0, 19'd1); push1(1, 19'd2); push1(2, 19'd3); push1(3, 19'd4);
    tick();
    chk_state(2'b01, 1'b0);
    rd(4'b0001, 1'b1);
    rd(4'b1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_port_sched.md
Name: io_port_sched

Overview:
- Port scheduler and run controller around the float soft-processor wrapper.
- Input side: buffers NUIOIN integer input streams (valid/ready) in small per-port FIFOs and serves the word selected by the one-hot decoded req_in strobe onto the processor's io_in.
- Output side: captures io_out into NUIOOU output holding registers on the out_en strobes and presents them downstream with valid/ready.
- Sequencing: holds the processor in reset until every input stream is primed, and optionally halts it on I/O errors.

Parameters:
- NUIOIN, 4, number of input ports (width of req_in).
- NUIOOU, 4, number of output ports (width of out_en).
- NBIN, 19, integer input word width (io_in).
- NBOUT, 28, integer output word width (io_out).
- FDEPTH, 2, log2 of per-input FIFO depth (4 entries).
- HALT_ERR, 1, 1 = halt processor on any sticky error; 0 = flag only.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  NUIOIN*NBIN  packed input words; port i at [i*NBIN +: NBIN].
- s_valid  in  NUIOIN  input word valid per port.
- s_ready  out  NUIOIN  FIFO not full per port.
- req_in  in  NUIOIN  one-hot read strobe from processor address decoder.
- io_in  out  NBIN  signed word to processor (int2float input).
- out_en  in  NUIOOU  one-hot write strobe from processor address decoder.
- io_out  in  NBOUT  signed word from processor (float2int output).
- m_data  out  NUIOOU*NBOUT  packed output registers.
- m_valid  out  NUIOOU  output register full.
- m_ready  in  NUIOOU  downstream accept.
- clr_err  in  1  clears sticky errors and restarts sequencing.
- proc_rst  out  1  reset to processor, active-high.
- err_uf  out  NUIOIN  sticky underflow per input port.
- err_ov  out  NUIOOU  sticky overflow per output port.
- state  out  2  FSM state.

Behaviour:
- Reset values:
  - FIFOs empty; s_ready = all 1 one cycle after rst deasserts (0 during rst).
  - m_valid = 0, m_data = 0, err_uf = 0, err_ov = 0.
  - state = FILL, proc_rst = 1, io_in = 0.
- Input FIFO:
  - Push on s_valid[i] & s_ready[i].
  - s_ready[i] = count < 2**FDEPTH; a full FIFO does not accept, even with a same-cycle pop.
  - Pointers wrap modulo depth; count is FDEPTH+1 bits.
- Read path:
  - io_in is combinational: head of the FIFO for the lowest set bit of req_in; 0 if req_in = 0.
  - The served FIFO pops on the same clock edge. Higher set bits are ignored: no pop, no error.
  - req_in to an empty FIFO: io_in = 0, no pop, err_uf[i] set.
  - Push and pop on the same port in the same cycle: count unchanged; empty FIFO pops nothing (underflow applies).
- Write path:
  - out_en[j] on an edge: m_data[j] <= io_out, m_valid[j] <= 1. Lowest set bit only.
  - Overflow: out_en[j] while m_valid[j] & !m_ready[j] overwrites the data and sets err_ov[j].
  - out_en[j] together with m_valid[j] & m_ready[j]: new data, m_valid stays 1, no error.
  - m_ready[j] alone clears m_valid[j]; m_data holds its value.
- Strobes are ignored (no pop, no capture, no error) while proc_rst = 1.
- FSM (2'b00 FILL, 2'b01 RUN, 2'b10 HALT):
  - FILL -> RUN when every FIFO count >= 1.
  - RUN -> HALT when HALT_ERR = 1 and any err bit is set (next cycle after the error register sets).
  - HALT -> FILL on clr_err.
  - clr_err in any state clears err_uf and err_ov next cycle. In RUN it does not change state.
  - proc_rst = (state != RUN), registered: rises on the same edge the state leaves RUN.
- FIFOs and output registers keep contents across HALT and FILL; only rst flushes them.
- Async rst mid-operation: everything returns to reset values immediately, including discarding buffered data.

Decomposition:
- Package io_sched_pkg: state encodings FILL/RUN/HALT; a function returning the lowest-set-bit index of a one-hot vector.
- One sub-module io_sfifo (params W, AW): synchronous FIFO with push, pop, head data, count, full, empty, async active-high rst. Instantiated NUIOIN times in a generate loop.

Test Plan:
- Priming: push 5, 7, 9 on ports 0..2, nothing on port 3 -> state stays FILL, proc_rst = 1. Push -3 on port 3 -> next edge state = RUN, proc_rst = 0.
- Read order: port 1 FIFO holds 11, 22; req_in = 4'b0010 twice -> io_in = 11 then 22. Third pulse -> io_in = 0, err_uf = 4'b0010; with HALT_ERR = 1, state = HALT and proc_rst = 1.
- FIFO full: 4 pushes to port 0 with no pops -> s_ready[0] = 0; a 5th word held valid is not consumed. One pop -> s_ready[0] = 1 and the word enters.
- Output handshake: out_en = 4'b0100, io_out = 123456 -> m_valid[2] = 1, m_data[2] = 123456. m_ready[2] -> m_valid[2] = 0.
- Overflow: m_valid[0] = 1, m_ready = 0, out_en = 4'b0001 with io_out = -5 -> m_data[0] = -5, err_ov[0] = 1. clr_err in HALT -> errors 0, state FILL, re-enters RUN since FIFOs are still primed.
- Async reset: assert rst mid-RUN between edges -> proc_rst = 1, m_valid = 0, FIFOs empty immediately.
